// File: rtl/huffman_packer.sv
// huffman_packer: run-time programmable Huffman coder that packs variable-length
// codes MSB-first into OUT_W-bit words, with a flush that drains a zero-padded
// final word marked by m_last.
// Optional build macro HUFF_BITCNT_EN adds a saturating 32-bit total_bits output
// counting the code bits of every accepted, programmed symbol.
module huffman_packer #(
    parameter int SYM_W   = 7,
    parameter int MAX_LEN = 10,
    parameter int OUT_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tbl_we,
    input  logic [SYM_W-1:0]   tbl_addr,
    input  logic [MAX_LEN-1:0] tbl_code,
    input  logic [LEN_W-1:0]   tbl_len,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SYM_W-1:0]   s_sym,
    input  logic               flush,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [OUT_W-1:0]   m_data,
    output logic               m_last,
    output logic               flush_done,
    output logic               err
`ifdef HUFF_BITCNT_EN
    ,
    output logic [31:0]        total_bits
`endif
);

    localparam int DEPTH = 1 << SYM_W;
    localparam int ACC_W = OUT_W + MAX_LEN;
    localparam int CNT_W = $clog2(ACC_W + 1);

    typedef enum logic {RUN, DRAIN} state_t;

    logic [MAX_LEN-1:0] code_q [DEPTH];
    logic [LEN_W-1:0]   len_q  [DEPTH];

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               m_valid_q;
    logic [OUT_W-1:0]   m_data_q;
    logic               m_last_q;
    logic               done_q, done_d;
    logic               err_q;

    logic [MAX_LEN-1:0] lk_code;
    logic [LEN_W-1:0]   lk_len;
    logic [ACC_W-1:0]   code_ext;
    logic [CNT_W-1:0]   shamt;
    logic               accept, sym_ok, sym_drop, tbl_bad;
    logic               can_emit, drain_last, emit;

    // Lookup reads the registered table, so a same-cycle write is seen only by later accepts.
    assign lk_code    = code_q[s_sym];
    assign lk_len     = len_q[s_sym];
    assign s_ready    = (state_q == RUN) && (cnt_q < CNT_W'(OUT_W));
    assign accept     = s_valid && s_ready;
    assign sym_ok     = accept && (lk_len != '0);
    assign sym_drop   = accept && (lk_len == '0);
    assign tbl_bad    = tbl_we && (tbl_len > LEN_W'(MAX_LEN));
    assign can_emit   = !m_valid_q || m_ready;
    assign drain_last = (state_q == DRAIN) && (cnt_q <= CNT_W'(OUT_W));
    assign emit       = can_emit && ((cnt_q >= CNT_W'(OUT_W)) || drain_last);
    assign code_ext   = ACC_W'(lk_code) & ((ACC_W'(1) << lk_len) - ACC_W'(1));
    assign shamt      = CNT_W'(ACC_W) - cnt_q - CNT_W'(lk_len);

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign flush_done = done_q;
    assign err        = err_q;

    // Next accumulator, bit count and drain state; accept and emit never coincide.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        done_d  = 1'b0;
        if (sym_ok) begin
            acc_d = acc_q | (code_ext << shamt);
            cnt_d = cnt_q + CNT_W'(lk_len);
        end
        if (emit) begin
            if (drain_last) begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
                done_d  = 1'b1;
            end else begin
                acc_d = acc_q << OUT_W;
                cnt_d = cnt_q - CNT_W'(OUT_W);
            end
        end
        if ((state_q == RUN) && flush) begin
            if (cnt_d == '0) done_d  = 1'b1;
            else             state_d = DRAIN;
        end
    end

    // Code table: cleared on reset, over-long writes rejected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                code_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if (tbl_we && !tbl_bad) begin
            code_q[tbl_addr] <= tbl_code;
            len_q[tbl_addr]  <= tbl_len;
        end
    end

    // Packer FSM with registered output word, last/done flags and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            acc_q     <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (emit) begin
                m_valid_q <= 1'b1;
                m_data_q  <= acc_q[ACC_W-1 -: OUT_W];
                m_last_q  <= drain_last;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (sym_drop || tbl_bad) err_q <= 1'b1;
        end
    end

`ifdef HUFF_BITCNT_EN
    logic [31:0] total_q;
    logic [32:0] total_sum;

    assign total_sum  = {1'b0, total_q} + 33'(lk_len);
    assign total_bits = total_q;

    // Saturating count of packed code bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       total_q <= '0;
        else if (sym_ok) total_q <= total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
    end
`endif

endmodule

// File: tb/tb_huffman_packer.sv
// Self-checking bench for huffman_packer: bit-queue reference model feeding a
// scoreboard of expected output words, plus directed checks on handshake,
// flush, error and reset behaviour.
module tb_huffman_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        tbl_we;
    logic [6:0]  tbl_addr;
    logic [9:0]  tbl_code;
    logic [3:0]  tbl_len;
    logic        s_valid;
    logic        s_ready;
    logic [6:0]  s_sym;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic        flush_done;
    logic        err;
`ifdef HUFF_BITCNT_EN
    logic [31:0] total_bits;
`endif

    int checks = 0;
    int errors = 0;

    logic [16:0] sb[$];
    logic [15:0] rx[$];
    bit          mbits[$];
    logic [9:0]  tcode [128];
    logic [3:0]  tlen  [128];
    logic [31:0] mtotal;

    huffman_packer #(.SYM_W(7), .MAX_LEN(10), .OUT_W(16), .LEN_W(4)) dut (
        .clk(clk), .reset(reset),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_sym(s_sym),
        .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .flush_done(flush_done), .err(err)
`ifdef HUFF_BITCNT_EN
        , .total_bits(total_bits)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every handshaken word is compared with the oldest expected word.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", {15'd0, m_last, m_data}, 32'hDEAD_0000);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                chk("word", {15'd0, m_last, m_data}, {15'd0, e});
            end
            rx.push_back(m_data);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_word(input bit last);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) w[15-i] = (mbits.size() != 0) ? mbits.pop_front() : 1'b0;
        sb.push_back({last, w});
    endtask

    task automatic model_sym(input logic [6:0] sym);
        int len;
        len = int'(tlen[sym]);
        if (len != 0) begin
            for (int i = len - 1; i >= 0; i--) mbits.push_back(tcode[sym][i]);
            mtotal = (mtotal > 32'hFFFF_FFFF - 32'(len)) ? 32'hFFFF_FFFF : mtotal + 32'(len);
            while (mbits.size() >= 16) push_word(1'b0);
        end
    endtask

    task automatic tbl_write(input logic [6:0] a, input logic [9:0] c, input logic [3:0] l);
        tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
        step();
        tbl_we = 1'b0;
        if (l <= 4'd10) begin
            tcode[a] = c;
            tlen[a]  = l;
        end
    endtask

    task automatic send(input logic [6:0] sym);
        int n;
        n = 0;
        s_valid = 1'b1; s_sym = sym;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
        model_sym(sym);
        step();
        s_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        if (mbits.size() != 0) push_word(1'b1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!flush_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, flush_done, 1'b1);
        @(negedge clk);
        chk({tag, "_pulse"}, flush_done, 1'b0);
    endtask

    task automatic wait_sb(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
        s_valid = 1'b0; s_sym = '0; flush = 1'b0; m_ready = 1'b1;
        mtotal = '0;
        for (int i = 0; i < 128; i++) begin
            tcode[i] = '0;
            tlen[i]  = '0;
        end

        // Reset state
        @(negedge clk);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 16'h0000);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
        step();
        reset = 1'b0;

        // Packing across a word boundary, then drain the partial word
        tbl_write(7'h41, 10'b101, 4'd3);
        tbl_write(7'h42, 10'b01, 4'd2);
        repeat (5) send(7'h41);
        send(7'h42);
        pulse_flush();
        @(negedge clk);
        chk("drain_s_ready", s_ready, 1'b0);
        wait_done("t1_flush_done");
        wait_sb("t1_sb_empty");
        chk("t1_word0", rx[0], 16'hB6DA);
        chk("t1_word1", rx[1], 16'h8000);
`ifdef HUFF_BITCNT_EN
        chk("t1_total_bits", total_bits, mtotal);
`endif
        step();

        // Backpressure: 33 bits with the sink stalled
        m_ready = 1'b0;
        repeat (11) send(7'h41);
        repeat (2) @(negedge clk);
        chk("bp_s_ready", s_ready, 1'b0);
        chk("bp_m_valid", m_valid, 1'b1);
        chk("bp_m_data", m_data, 16'hB6DB);
        repeat (3) @(negedge clk);
        chk("bp_hold_data", m_data, 16'hB6DB);
        chk("bp_hold_valid", m_valid, 1'b1);
        step();
        m_ready = 1'b1;
        wait_sb("t2_sb_empty");
        chk("t2_word0", rx[2], 16'hB6DB);
        chk("t2_word1", rx[3], 16'h6DB6);
        step();
        pulse_flush();
        wait_done("t2_flush_done");
        wait_sb("t2_drain_empty");
        chk("t2_word2", rx[4], 16'h8000);
        step();

        // Flush with nothing pending right after a full word
        repeat (8) send(7'h42);
        repeat (3) step();
        pulse_flush();
        @(negedge clk);
        chk("f0_flush_done", flush_done, 1'b1);
        chk("f0_m_valid", m_valid, 1'b0);
        chk("f0_s_ready", s_ready, 1'b1);
        @(negedge clk);
        chk("f0_flush_done_pulse", flush_done, 1'b0);
        chk("f0_no_word", m_valid, 1'b0);
        wait_sb("t3_sb_empty");
        chk("t3_word", rx[5], 16'h5555);
        chk("t3_err_clear", err, 1'b0);
        step();

        // Errors: unprogrammed symbol, over-long table write
        send(7'h10);
        @(negedge clk);
        chk("err_unprog", err, 1'b1);
        step();
        pulse_flush();
        @(negedge clk);
        chk("err_no_bits", flush_done, 1'b1);
        chk("err_no_word", m_valid, 1'b0);
        step();
        tbl_write(7'h41, 10'h3FF, 4'd12);
        @(negedge clk);
        chk("err_sticky", err, 1'b1);
        step();
        send(7'h41);
        pulse_flush();
        wait_done("t4_flush_done");
        wait_sb("t4_sb_empty");
        chk("t4_entry_kept", rx[6], 16'hA000);
        step();

        // Same-cycle table write and accept of one address
        tbl_we = 1'b1; tbl_addr = 7'h41; tbl_code = 10'b1; tbl_len = 4'd1;
        s_valid = 1'b1; s_sym = 7'h41;
        @(negedge clk);
        chk("wa_s_ready", s_ready, 1'b1);
        model_sym(7'h41);
        step();
        tbl_we = 1'b0; s_valid = 1'b0;
        tcode[7'h41] = 10'b1;
        tlen[7'h41]  = 4'd1;
        send(7'h41);
        pulse_flush();
        wait_done("t5_flush_done");
        wait_sb("t5_sb_empty");
        chk("t5_word", rx[7], 16'hB000);
`ifdef HUFF_BITCNT_EN
        chk("t5_total_bits", total_bits, mtotal);
`endif
        step();

        // Reset in the middle of a word with a held output
        tbl_write(7'h41, 10'b101, 4'd3);
        m_ready = 1'b0;
        repeat (5) send(7'h41);
        send(7'h42);
        repeat (2) send(7'h41);
        @(negedge clk);
        chk("mr_m_valid_before", m_valid, 1'b1);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("mr_m_valid", m_valid, 1'b0);
        chk("mr_s_ready", s_ready, 1'b1);
        chk("mr_m_data", m_data, 16'h0000);
        step();
        reset = 1'b0;
        m_ready = 1'b1;
        sb.delete();
        mbits.delete();
        mtotal = '0;
        for (int i = 0; i < 128; i++) begin
            tcode[i] = '0;
            tlen[i]  = '0;
        end
        @(negedge clk);
        chk("mr_err", err, 1'b0);
`ifdef HUFF_BITCNT_EN
        chk("mr_total_bits", total_bits, 32'd0);
`endif
        step();
        send(7'h41);
        @(negedge clk);
        chk("mr_tbl_cleared", err, 1'b1);
        step();
        pulse_flush();
        @(negedge clk);
        chk("mr_flush_done", flush_done, 1'b1);
        chk("mr_no_word", m_valid, 1'b0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
